// File: rtl/rc4_encryption_core.sv
// rc4_encryption_core
// RC4 encryptor with a fixed 24-bit key. It uses an external 256-byte S memory,
// reads plaintext from an external RAM and writes ciphertext to another RAM.
// Every external read has the same shape: drive the address, wait one cycle,
// capture the data on the next cycle.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, secret_key      run request and key (key latched when start is accepted)
//   s_address/s_data/s_wren/s_q   S memory port
//   pt_address/pt_q        plaintext RAM read port
//   ct_address/ct_data/ct_wren    ciphertext RAM write port
//   busy, done             run status (done held until the next accepted start)
//
// Every output is a register. The combinational block computes the output
// values for the state being entered, so the address for a READ state is
// already on the bus during that state.
module rc4_encryption_core #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  input  logic [7:0]  s_q,
  output logic [4:0]  pt_address,
  input  logic [7:0]  pt_q,
  output logic [4:0]  ct_address,
  output logic [7:0]  ct_data,
  output logic        ct_wren,
  output logic        busy,
  output logic        done
);

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_READ_I, K_WAIT_I, K_CAP_I, K_READ_J, K_WAIT_J, K_CAP_J, K_WR_I, K_WR_J,
    P_READ_I, P_WAIT_I, P_CAP_I, P_READ_J, P_WAIT_J, P_CAP_J, P_WR_I, P_WR_J,
    P_READ_F, P_WAIT_F, P_CAP_F, P_WR_CT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  i, i_n, j, j_n, si, si_n, sj, sj_n;
  logic [4:0]  k, k_n;
  logic [1:0]  kidx, kidx_n;    // i mod 3, tracked alongside i during KSA
  logic [23:0] key_q, key_n;
  logic [7:0]  key_byte;
  logic [7:0]  s_address_n, s_data_n, ct_data_n;
  logic [4:0]  pt_address_n, ct_address_n;
  logic        s_wren_n, ct_wren_n, busy_n, done_n;

  always_comb begin
    case (kidx)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      si         <= '0;
      sj         <= '0;
      kidx       <= '0;
      key_q      <= '0;
      s_address  <= '0;
      s_data     <= '0;
      s_wren     <= 1'b0;
      pt_address <= '0;
      ct_address <= '0;
      ct_data    <= '0;
      ct_wren    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      i          <= i_n;
      j          <= j_n;
      k          <= k_n;
      si         <= si_n;
      sj         <= sj_n;
      kidx       <= kidx_n;
      key_q      <= key_n;
      s_address  <= s_address_n;
      s_data     <= s_data_n;
      s_wren     <= s_wren_n;
      pt_address <= pt_address_n;
      ct_address <= ct_address_n;
      ct_data    <= ct_data_n;
      ct_wren    <= ct_wren_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    i_n          = i;
    j_n          = j;
    k_n          = k;
    si_n         = si;
    sj_n         = sj;
    kidx_n       = kidx;
    key_n        = key_q;
    s_address_n  = s_address;
    s_data_n     = s_data;
    s_wren_n     = 1'b0;
    pt_address_n = pt_address;
    ct_address_n = ct_address;
    ct_data_n    = ct_data;
    ct_wren_n    = 1'b0;
    busy_n       = busy;
    done_n       = done;

    case (state)
      IDLE: if (start) begin
        key_n       = secret_key;
        done_n      = 1'b0;
        busy_n      = 1'b1;
        i_n         = '0;
        j_n         = '0;
        k_n         = '0;
        state_n     = INIT;
        s_address_n = '0;
        s_data_n    = '0;
        s_wren_n    = 1'b1;
      end
      INIT: begin
        if (i == 8'hFF) begin
          i_n         = '0;
          kidx_n      = '0;
          s_address_n = '0;
          state_n     = K_READ_I;
        end else begin
          i_n         = i + 8'd1;
          s_address_n = i + 8'd1;
          s_data_n    = i + 8'd1;
          s_wren_n    = 1'b1;
        end
      end
      K_READ_I: state_n = K_WAIT_I;
      K_WAIT_I: state_n = K_CAP_I;
      K_CAP_I: begin
        si_n        = s_q;
        j_n         = j + s_q + key_byte;
        s_address_n = j + s_q + key_byte;
        state_n     = K_READ_J;
      end
      K_READ_J: state_n = K_WAIT_J;
      K_WAIT_J: state_n = K_CAP_J;
      K_CAP_J: begin
        sj_n        = s_q;
        s_address_n = i;
        s_data_n    = s_q;
        s_wren_n    = 1'b1;
        state_n     = K_WR_I;
      end
      K_WR_I: begin
        s_address_n = j;
        s_data_n    = si;
        s_wren_n    = 1'b1;
        state_n     = K_WR_J;
      end
      K_WR_J: begin
        if (i == 8'hFF) begin
          // PRGA pre-increments i, so its first read address is 1.
          i_n         = 8'd1;
          j_n         = '0;
          s_address_n = 8'd1;
          state_n     = P_READ_I;
        end else begin
          i_n         = i + 8'd1;
          kidx_n      = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          s_address_n = i + 8'd1;
          state_n     = K_READ_I;
        end
      end
      P_READ_I: state_n = P_WAIT_I;
      P_WAIT_I: state_n = P_CAP_I;
      P_CAP_I: begin
        si_n        = s_q;
        j_n         = j + s_q;
        s_address_n = j + s_q;
        state_n     = P_READ_J;
      end
      P_READ_J: state_n = P_WAIT_J;
      P_WAIT_J: state_n = P_CAP_J;
      P_CAP_J: begin
        sj_n        = s_q;
        s_address_n = i;
        s_data_n    = s_q;
        s_wren_n    = 1'b1;
        state_n     = P_WR_I;
      end
      P_WR_I: begin
        s_address_n = j;
        s_data_n    = si;
        s_wren_n    = 1'b1;
        state_n     = P_WR_J;
      end
      P_WR_J: begin
        s_address_n  = si + sj;
        pt_address_n = k;
        state_n      = P_READ_F;
      end
      P_READ_F: state_n = P_WAIT_F;
      P_WAIT_F: state_n = P_CAP_F;
      P_CAP_F: begin
        ct_address_n = k;
        ct_data_n    = s_q ^ pt_q;
        ct_wren_n    = 1'b1;
        state_n      = P_WR_CT;
      end
      P_WR_CT: begin
        if (k == 5'(MSG_LEN - 1)) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          k_n         = k + 5'd1;
          i_n         = i + 8'd1;
          s_address_n = i + 8'd1;
          state_n     = P_READ_I;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_encryption_core.sv
// Directed bench for rc4_encryption_core with 9-byte messages and behavioural
// S, plaintext and ciphertext RAMs (one-cycle registered reads).
module tb_rc4_encryption_core;
  localparam int unsigned MSG_LEN  = 9;
  localparam int unsigned RUN_LEN  = 256 + 2048 + 12 * MSG_LEN;
  localparam int unsigned S_WRITES = 256 + 512 + 2 * MSG_LEN;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  s_address, s_data, s_q, pt_q, ct_data;
  logic        s_wren, ct_wren, busy, done;
  logic [4:0]  pt_address, ct_address;

  rc4_encryption_core #(.MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .pt_address(pt_address), .pt_q(pt_q),
    .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [32];
  logic [7:0] ct_mem [32];

  // Bus monitors; clr is raised by the tasks for one edge to restart counts.
  logic        clr = 1'b0;
  int unsigned busy_cnt = 0, s_wr_cnt = 0, ct_cnt = 0;
  int unsigned ct_cyc_log  [32];
  logic [4:0]  ct_addr_log [32];

  always @(posedge clk) begin
    s_q  <= s_mem[s_address];
    pt_q <= pt_mem[pt_address];
    if (s_wren)  s_mem[s_address]  <= s_data;
    if (ct_wren) ct_mem[ct_address] <= ct_data;
    if (clr) begin
      busy_cnt <= 0;
      s_wr_cnt <= 0;
      ct_cnt   <= 0;
    end else begin
      if (busy)   busy_cnt <= busy_cnt + 1;
      if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
      if (ct_wren) begin
        if (ct_cnt < 32) begin
          ct_cyc_log[ct_cnt]  <= busy_cnt + 1;
          ct_addr_log[ct_cnt] <= ct_address;
        end
        ct_cnt <= ct_cnt + 1;
      end
    end
  end

  int unsigned compared = 0, mismatched = 0;
  logic [7:0] exp_ct [MSG_LEN] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] first_ct [MSG_LEN];

  task automatic load_pt(input string msg);
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = msg[n];
  endtask

  task automatic pulse_start(input logic [23:0] key);
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL done_timeout: done=%0b required 1 within 5000 cycles", done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, done, s_wren, ct_wren} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b required 0000", {busy, done, s_wren, ct_wren});
    end
    compared++;
    if ({s_address, s_data, pt_address, ct_address, ct_data} !== 34'd0) begin
      mismatched++;
      $display("FAIL reset_buses: got %h required 0", {s_address, s_data, pt_address, ct_address, ct_data});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vector;
    bit ok;
    load_pt("Plaintext");
    pulse_start(24'h4B6579);
    wait_done(ok);
    for (int n = 0; n < MSG_LEN; n++) begin
      compared++;
      if (ct_mem[n] !== exp_ct[n]) begin
        mismatched++;
        $display("FAIL ct_byte[%0d]: got %h required %h", n, ct_mem[n], exp_ct[n]);
      end
    end
    compared++;
    if (busy_cnt != RUN_LEN) begin
      mismatched++;
      $display("FAIL busy_length: got %0d required %0d", busy_cnt, RUN_LEN);
    end
    compared++;
    if (s_wr_cnt != S_WRITES) begin
      mismatched++;
      $display("FAIL s_wren_count: got %0d required %0d", s_wr_cnt, S_WRITES);
    end
    compared++;
    if (ct_cnt != MSG_LEN) begin
      mismatched++;
      $display("FAIL ct_wren_count: got %0d required %0d", ct_cnt, MSG_LEN);
    end
    for (int n = 0; n < MSG_LEN; n++) begin
      compared++;
      if (ct_addr_log[n] !== 5'(n) || ct_cyc_log[n] != 2304 + 12 * n + 12) begin
        mismatched++;
        $display("FAIL ct_write[%0d]: got addr %0d cycle %0d required addr %0d cycle %0d",
                 n, ct_addr_log[n], ct_cyc_log[n], n, 2304 + 12 * n + 12);
      end
    end
    compared++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL done_hold: got done=%b busy=%b required done=1 busy=0", done, busy);
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    bit seen;
    for (int n = 0; n < 32; n++) ct_mem[n] = 8'h00;
    load_pt("Plaintext");
    pulse_start(24'h4B6579);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (busy) seen = 1'b1;
      else @(negedge clk);
    end
    repeat (49) @(negedge clk);
    secret_key = 24'h123456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    for (int n = 0; n < MSG_LEN; n++) begin
      compared++;
      if (ct_mem[n] !== exp_ct[n]) begin
        mismatched++;
        $display("FAIL ignored_start_ct[%0d]: got %h required %h", n, ct_mem[n], exp_ct[n]);
      end
    end
    compared++;
    if (busy_cnt != RUN_LEN) begin
      mismatched++;
      $display("FAIL ignored_start_busy: got %0d required %0d", busy_cnt, RUN_LEN);
    end
  endtask

  task automatic test_reset_mid_run;
    load_pt("Plaintext");
    pulse_start(24'h4B6579);
    repeat (999) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    compared++;
    if ({busy, done, s_wren, ct_wren, s_address, s_data, pt_address, ct_address, ct_data} !== 38'd0) begin
      mismatched++;
      $display("FAIL abort_outputs: got %h required 0",
               {busy, done, s_wren, ct_wren, s_address, s_data, pt_address, ct_address, ct_data});
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clr = 1'b0;
    repeat (300) @(negedge clk);
    compared++;
    if (ct_cnt != 0 || s_wr_cnt != 0) begin
      mismatched++;
      $display("FAIL abort_writes: got ct=%0d s=%0d required 0 0", ct_cnt, s_wr_cnt);
    end
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    load_pt("Plaintext");
    pulse_start(24'h4B6579);
    wait_done(ok);
    for (int n = 0; n < MSG_LEN; n++) first_ct[n] = ct_mem[n];
    for (int n = 0; n < 32; n++) ct_mem[n] = 8'h00;
    pulse_start(24'h4B6579);
    wait_done(ok);
    for (int n = 0; n < MSG_LEN; n++) begin
      compared++;
      if (ct_mem[n] !== exp_ct[n] || first_ct[n] !== exp_ct[n]) begin
        mismatched++;
        $display("FAIL back_to_back[%0d]: got %h then %h required %h", n, first_ct[n], ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_round_trip;
    bit ok;
    string msg = "roundtrip";
    load_pt(msg);
    pulse_start(24'h0AAAAA);
    wait_done(ok);
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = ct_mem[n];
    compared++;
    if (ct_mem[0] === msg[0]) begin
      mismatched++;
      $display("FAIL round_trip_cipher: got %h required a value other than %h", ct_mem[0], msg[0]);
    end
    pulse_start(24'h0AAAAA);
    wait_done(ok);
    for (int n = 0; n < MSG_LEN; n++) begin
      compared++;
      if (ct_mem[n] !== msg[n]) begin
        mismatched++;
        $display("FAIL round_trip[%0d]: got %h required %h", n, ct_mem[n], msg[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_start_ignored();
    test_reset_mid_run();
    test_known_vector();
    test_back_to_back();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
